tetris_engine: RTL and testbench

- Sequential, parametrised successor to the single-cycle combinational play-field update.
- Board size and spawn point are parameters.
- Moves, gravity, hard drop, locking and row clearing run as a multi-cycle FSM, one board operation per cycle.
- Sits between the keyboard/load-gen command stream and the display/score blocks. It owns the static board and the floating piece.

---
 rtl/tetris_engine_if.sv | 10 +
 rtl/tetris_engine.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_tetris_engine.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_engine_if.sv
// Command stream into the play-field engine: valid/ready, one command per accepted beat.
// Ready is only offered while a piece is under player control.
interface tetris_engine_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd, output cmd_ready);
endinterface

// File: rtl/tetris_engine.sv
// Play-field engine: one board operation per cycle, commands act on the cycle they are accepted.
// cmd_ready only in PLAY (stalls in SPAWN/DROP/LOCK/CLEAR/OVER); `TETRIS_HOLD_EN enables hold (cmd 7).
module tetris_engine #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int SPAWN_X = 3,
    parameter int SPAWN_Y = BOARD_H + 3,
    parameter int XW      = 5,
    parameter int YW      = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    tetris_engine_if.slave              cmd_if,
    input  logic                        gravity_tick,
    input  logic [2:0]                  rand_piece,
    output logic [BOARD_W*BOARD_H-1:0]  board,
    output logic signed [XW-1:0]        piece_x,
    output logic [YW-1:0]               piece_y,
    output logic [15:0]                 piece_shape,
    output logic [3:0]                  hold_piece,
    output logic                        game_over,
    output logic                        lines_valid,
    output logic [2:0]                  lines_count,
    output logic                        busy
);
    localparam int N  = BOARD_W * BOARD_H;
    localparam int RW = $clog2(BOARD_H + 1);
    localparam logic signed [XW-1:0] SPX   = XW'(SPAWN_X);
    localparam logic [YW-1:0]        SPY   = YW'(SPAWN_Y);
    localparam logic signed [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0]        Y_ONE = YW'(1);
    localparam logic [RW-1:0]        R_ONE = RW'(1);
    localparam logic [RW-1:0]        R_END = RW'(BOARD_H);

    typedef enum logic [2:0] {S_OVER, S_SPAWN, S_PLAY, S_DROP, S_LOCK, S_CLEAR} state_t;

    function automatic logic [15:0] shape_of(input logic [2:0] code);
        case (code)
            3'd0:    shape_of = 16'h4444;
            3'd1:    shape_of = 16'h0740;
            3'd2:    shape_of = 16'h0E20;
            3'd3:    shape_of = 16'h0C60;
            3'd4:    shape_of = 16'h06C0;
            3'd5:    shape_of = 16'h0E40;
            default: shape_of = 16'h0660;
        endcase
    endfunction

    function automatic logic [15:0] rot_cw(input logic [15:0] s);
        rot_cw = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                rot_cw[15-(4*r+c)] = s[15-(4*(3-c)+r)];
    endfunction

    function automatic logic [15:0] rot_ccw(input logic [15:0] s);
        rot_ccw = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                rot_ccw[15-(4*r+c)] = s[15-(4*c+(3-r))];
    endfunction

    // Rows at or above BOARD_H are the hidden spawn area: legal and always empty.
    function automatic logic collides(input logic [N-1:0] b, input logic [15:0] s,
                                      input int x, input int y);
        int col;
        int row;
        collides = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                col = x + c;
                row = y - r;
                if (s[15-(4*r+c)]) begin
                    if (col < 0 || col >= BOARD_W || row < 0)
                        collides = 1'b1;
                    else if (row < BOARD_H && b[row*BOARD_W + col])
                        collides = 1'b1;
                end
            end
    endfunction

    function automatic logic [N-1:0] merge_piece(input logic [N-1:0] b, input logic [15:0] s,
                                                 input int x, input int y);
        int col;
        int row;
        merge_piece = b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                col = x + c;
                row = y - r;
                if (s[15-(4*r+c)] && row >= 0 && row < BOARD_H && col >= 0 && col < BOARD_W)
                    merge_piece[row*BOARD_W + col] = 1'b1;
            end
    endfunction

    function automatic logic above_top(input logic [15:0] s, input int y);
        above_top = 1'b0;
        for (int r = 0; r < 4; r++)
            if (|s[15-4*r -: 4] && (y - r) >= BOARD_H)
                above_top = 1'b1;
    endfunction

    function automatic logic [N-1:0] shift_down(input logic [N-1:0] b, input int r);
        shift_down = b;
        for (int i = 0; i < BOARD_H - 1; i++)
            if (i >= r)
                shift_down[i*BOARD_W +: BOARD_W] = b[(i+1)*BOARD_W +: BOARD_W];
        shift_down[(BOARD_H-1)*BOARD_W +: BOARD_W] = '0;
    endfunction

    state_t                state_q, state_d;
    logic [N-1:0]          board_q, board_d;
    logic [15:0]           shape_q, shape_d;
    logic signed [XW-1:0]  x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic                  grav_pend_q, grav_pend_d;
    logic [RW-1:0]         row_q, row_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  lines_valid_q, lines_valid_d;
    logic [2:0]            lines_count_q, lines_count_d;
`ifdef TETRIS_HOLD_EN
    logic [3:0]            hold_q, hold_d;
    logic [2:0]            code_q, code_d;
    logic                  hold_used_q, hold_used_d;
    logic                  keep_hold_q, keep_hold_d;
    logic                  hit_hold;
`endif

    int          xi;
    int          yi;
    logic [15:0] cw_shape, ccw_shape, spawn_shape;
    logic        hit_left, hit_right, hit_down, hit_cw, hit_ccw, hit_spawn;
    logic        row_full;

    assign xi          = int'(x_q);
    assign yi          = int'(y_q);
    assign cw_shape    = rot_cw(shape_q);
    assign ccw_shape   = rot_ccw(shape_q);
    assign spawn_shape = shape_of(rand_piece);
    assign hit_left    = collides(board_q, shape_q, xi - 1, yi);
    assign hit_right   = collides(board_q, shape_q, xi + 1, yi);
    assign hit_down    = collides(board_q, shape_q, xi, yi - 1);
    assign hit_cw      = collides(board_q, cw_shape, xi, yi);
    assign hit_ccw     = collides(board_q, ccw_shape, xi, yi);
    assign hit_spawn   = collides(board_q, spawn_shape, SPAWN_X, SPAWN_Y);
    assign row_full    = (row_q < R_END) && (&board_q[row_q*BOARD_W +: BOARD_W]);
`ifdef TETRIS_HOLD_EN
    assign hit_hold    = collides(board_q, shape_of(hold_q[2:0]), SPAWN_X, SPAWN_Y);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_OVER;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        shape_d       = shape_q;
        x_d           = x_q;
        y_d           = y_q;
        grav_pend_d   = grav_pend_q;
        row_d         = row_q;
        cnt_d         = cnt_q;
        lines_valid_d = 1'b0;
        lines_count_d = lines_count_q;
`ifdef TETRIS_HOLD_EN
        hold_d        = hold_q;
        code_d        = code_q;
        hold_used_d   = hold_used_q;
        keep_hold_d   = keep_hold_q;
`endif
        if (start) begin
            state_d     = S_SPAWN;
            board_d     = '0;
            grav_pend_d = 1'b0;
`ifdef TETRIS_HOLD_EN
            hold_d      = 4'hF;
            hold_used_d = 1'b0;
            keep_hold_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_SPAWN: begin
                    shape_d = spawn_shape;
                    x_d     = SPX;
                    y_d     = SPY;
                    state_d = hit_spawn ? S_OVER : S_PLAY;
`ifdef TETRIS_HOLD_EN
                    code_d      = rand_piece;
                    keep_hold_d = 1'b0;
                    if (!keep_hold_q) hold_used_d = 1'b0;
`endif
                end
                S_PLAY: begin
                    if (cmd_if.cmd_valid) begin
                        if (gravity_tick) grav_pend_d = 1'b1;
                        case (cmd_if.cmd)
                            3'd1: if (!hit_cw)    shape_d = cw_shape;
                            3'd2: if (!hit_ccw)   shape_d = ccw_shape;
                            3'd3: if (!hit_left)  x_d = x_q - X_ONE;
                            3'd4: if (!hit_right) x_d = x_q + X_ONE;
                            3'd5: if (hit_down) state_d = S_LOCK; else y_d = y_q - Y_ONE;
                            3'd6: state_d = S_DROP;
`ifdef TETRIS_HOLD_EN
                            3'd7: if (!hold_used_q) begin
                                hold_used_d = 1'b1;
                                hold_d      = {1'b0, code_q};
                                if (hold_q == 4'hF) begin
                                    keep_hold_d = 1'b1;
                                    state_d     = S_SPAWN;
                                end else begin
                                    code_d  = hold_q[2:0];
                                    shape_d = shape_of(hold_q[2:0]);
                                    x_d     = SPX;
                                    y_d     = SPY;
                                    if (hit_hold) state_d = S_OVER;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end else if (gravity_tick || grav_pend_q) begin
                        grav_pend_d = 1'b0;
                        if (hit_down) state_d = S_LOCK;
                        else          y_d = y_q - Y_ONE;
                    end
                    if (state_d != S_PLAY) grav_pend_d = 1'b0;
                end
                S_DROP: begin
                    if (hit_down) state_d = S_LOCK;
                    else          y_d = y_q - Y_ONE;
                end
                S_LOCK: begin
                    board_d = merge_piece(board_q, shape_q, xi, yi);
                    row_d   = '0;
                    cnt_d   = '0;
                    state_d = above_top(shape_q, yi) ? S_OVER : S_CLEAR;
                end
                S_CLEAR: begin
                    if (row_q == R_END) begin
                        if (cnt_q != 3'd0) begin
                            lines_valid_d = 1'b1;
                            lines_count_d = cnt_q;
                        end
                        state_d = S_SPAWN;
                    end else if (row_full) begin
                        // Re-test the same row: the row above has just dropped into it.
                        board_d = shift_down(board_q, int'(row_q));
                        cnt_d   = cnt_q + 3'd1;
                    end else begin
                        row_d = row_q + R_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_if.cmd_ready = (state_q == S_PLAY);
        game_over        = (state_q == S_OVER);
        busy             = (state_q == S_SPAWN) || (state_q == S_DROP) ||
                           (state_q == S_LOCK)  || (state_q == S_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q       <= '0;
            shape_q       <= '0;
            x_q           <= SPX;
            y_q           <= SPY;
            grav_pend_q   <= 1'b0;
            row_q         <= '0;
            cnt_q         <= '0;
            lines_valid_q <= 1'b0;
            lines_count_q <= '0;
`ifdef TETRIS_HOLD_EN
            hold_q        <= 4'hF;
            code_q        <= '0;
            hold_used_q   <= 1'b0;
            keep_hold_q   <= 1'b0;
`endif
        end else begin
            board_q       <= board_d;
            shape_q       <= shape_d;
            x_q           <= x_d;
            y_q           <= y_d;
            grav_pend_q   <= grav_pend_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            lines_valid_q <= lines_valid_d;
            lines_count_q <= lines_count_d;
`ifdef TETRIS_HOLD_EN
            hold_q        <= hold_d;
            code_q        <= code_d;
            hold_used_q   <= hold_used_d;
            keep_hold_q   <= keep_hold_d;
`endif
        end
    end

    assign board       = board_q;
    assign piece_x     = x_q;
    assign piece_y     = y_q;
    assign piece_shape = shape_q;
    assign lines_valid = lines_valid_q;
    assign lines_count = lines_count_q;
`ifdef TETRIS_HOLD_EN
    assign hold_piece  = hold_q;
`else
    assign hold_piece  = 4'hF;
`endif
endmodule

// File: tb/tb_tetris_engine.sv
// Directed bench for tetris_engine: builds boards through play, checks moves, clears, game over and reset.
module tb_tetris_engine;
    localparam int W = 10;
    localparam int H = 20;
    localparam int N = W * H;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              gravity_tick;
    logic [2:0]        rand_piece;
    logic [N-1:0]      board;
    logic signed [4:0] piece_x;
    logic [5:0]        piece_y;
    logic [15:0]       piece_shape;
    logic [3:0]        hold_piece;
    logic              game_over;
    logic              lines_valid;
    logic [2:0]        lines_count;
    logic              busy;

    int errors = 0;
    int checks = 0;

    tetris_engine_if cif();

    tetris_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_if(cif),
        .gravity_tick(gravity_tick), .rand_piece(rand_piece), .board(board),
        .piece_x(piece_x), .piece_y(piece_y), .piece_shape(piece_shape),
        .hold_piece(hold_piece), .game_over(game_over), .lines_valid(lines_valid),
        .lines_count(lines_count), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] c);
        cif.cmd_valid = 1'b1;
        cif.cmd       = c;
        tick();
        cif.cmd_valid = 1'b0;
        cif.cmd       = 3'd0;
    endtask

    task automatic wait_play(input string tag);
        int n = 0;
        while (!cif.cmd_ready && !game_over && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!cif.cmd_ready && !game_over) begin
            errors++;
            $display("FAIL %s_wait: cmd_ready=%0b after %0d cycles, required 1", tag, cif.cmd_ready, n);
        end
    endtask

    // Moves a freshly controlled piece sideways then hard-drops it; nr is the next spawn code.
    task automatic place_i(input int moves, input logic [2:0] nr);
        for (int i = 0; i < moves; i++) do_cmd(3'd4);
        for (int i = 0; i < -moves; i++) do_cmd(3'd3);
        rand_piece = nr;
        do_cmd(3'd6);
        wait_play("place");
    endtask

    task automatic test_reset();
        #12;
        checks += 10;
        if (game_over !== 1'b1)     begin errors++; $display("FAIL reset_game_over: got %b want 1", game_over); end
        if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cif.cmd_ready); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (board !== '0)           begin errors++; $display("FAIL reset_board: got %h want 0", board); end
        if (piece_shape !== 16'h0)  begin errors++; $display("FAIL reset_shape: got %h want 0000", piece_shape); end
        if (piece_x !== 5'sd3)      begin errors++; $display("FAIL reset_x: got %0d want 3", piece_x); end
        if (piece_y !== 6'd23)      begin errors++; $display("FAIL reset_y: got %0d want 23", piece_y); end
        if (hold_piece !== 4'hF)    begin errors++; $display("FAIL reset_hold: got %h want F", hold_piece); end
        if (lines_valid !== 1'b0)   begin errors++; $display("FAIL reset_lines_valid: got %b want 0", lines_valid); end
        if (lines_count !== 3'd0)   begin errors++; $display("FAIL reset_lines_count: got %0d want 0", lines_count); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cif.cmd_valid = 1'b1; cif.cmd = 3'd3; gravity_tick = 1'b1;
        tick(); tick();
        cif.cmd_valid = 1'b0; cif.cmd = 3'd0; gravity_tick = 1'b0;
        checks += 3;
        if (game_over !== 1'b1) begin errors++; $display("FAIL over_idle: game_over=%b want 1", game_over); end
        if (piece_x !== 5'sd3)  begin errors++; $display("FAIL over_idle_x: got %0d want 3", piece_x); end
        if (piece_y !== 6'd23)  begin errors++; $display("FAIL over_idle_y: got %0d want 23", piece_y); end
    endtask

    task automatic test_start();
        rand_piece = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 2;
        if (busy !== 1'b1)          begin errors++; $display("FAIL spawn_busy: got %b want 1", busy); end
        if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL spawn_ready: got %b want 0", cif.cmd_ready); end
        tick();
        checks += 6;
        if (cif.cmd_ready !== 1'b1)    begin errors++; $display("FAIL play_ready: got %b want 1", cif.cmd_ready); end
        if (piece_shape !== 16'h4444)  begin errors++; $display("FAIL play_shape: got %h want 4444", piece_shape); end
        if (piece_x !== 5'sd3)         begin errors++; $display("FAIL play_x: got %0d want 3", piece_x); end
        if (piece_y !== 6'd23)         begin errors++; $display("FAIL play_y: got %0d want 23", piece_y); end
        if (board !== '0)              begin errors++; $display("FAIL play_board: got %h want 0", board); end
        if (game_over !== 1'b0)        begin errors++; $display("FAIL play_over: got %b want 0", game_over); end
    endtask

    task automatic test_moves();
        for (int i = 0; i < 5; i++) do_cmd(3'd3);
        checks++;
        if (piece_x !== -5'sd1) begin errors++; $display("FAIL left_wall: got %0d want -1", piece_x); end
        for (int i = 0; i < 10; i++) do_cmd(3'd4);
        checks++;
        if (piece_x !== 5'sd8) begin errors++; $display("FAIL right_wall: got %0d want 8", piece_x); end
        do_cmd(3'd1);
        checks++;
        if (piece_shape !== 16'h4444) begin errors++; $display("FAIL rot_blocked: got %h want 4444", piece_shape); end
        for (int i = 0; i < 5; i++) do_cmd(3'd3);
        do_cmd(3'd1);
        checks++;
        if (piece_shape !== 16'h0F00) begin errors++; $display("FAIL rot_cw: got %h want 0F00", piece_shape); end
        do_cmd(3'd2);
        checks += 2;
        if (piece_shape !== 16'h4444) begin errors++; $display("FAIL rot_ccw: got %h want 4444", piece_shape); end
        if (piece_x !== 5'sd3)        begin errors++; $display("FAIL rot_x: got %0d want 3", piece_x); end
`ifndef TETRIS_HOLD_EN
        do_cmd(3'd7);
        checks += 3;
        if (hold_piece !== 4'hF)      begin errors++; $display("FAIL hold_off: got %h want F", hold_piece); end
        if (piece_shape !== 16'h4444) begin errors++; $display("FAIL hold_off_shape: got %h want 4444", piece_shape); end
        if (cif.cmd_ready !== 1'b1)   begin errors++; $display("FAIL hold_off_ready: got %b want 1", cif.cmd_ready); end
`endif
    endtask

    task automatic test_line_clear();
        logic [N-1:0] exp;
        logic [N-1:0] board_seen;
        logic [2:0]   cnt_seen;
        int           pulses;
        int           n;
        exp = '0;
        board_seen = '1;
        cnt_seen = 3'd0;
        pulses = 0;
        n = 0;
        for (int r = 0; r < 4; r++) exp[r*W +: W] = 10'h3FE;
        for (int col = 1; col <= 9; col++) place_i(col - 4, 3'd0);
        checks++;
        if (board !== exp) begin errors++; $display("FAIL prefill_board: got %h want %h", board, exp); end
        for (int i = 0; i < 4; i++) do_cmd(3'd3);
        rand_piece = 3'd0;
        do_cmd(3'd6);
        while (!cif.cmd_ready && n < 200) begin
            tick();
            n++;
            if (lines_valid) begin
                pulses++;
                cnt_seen = lines_count;
                board_seen = board;
            end
        end
        checks += 6;
        if (cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL clear_done: cmd_ready=%b want 1", cif.cmd_ready); end
        if (pulses != 1)            begin errors++; $display("FAIL clear_pulses: got %0d want 1", pulses); end
        if (cnt_seen !== 3'd4)      begin errors++; $display("FAIL clear_count: got %0d want 4", cnt_seen); end
        if (board_seen !== '0)      begin errors++; $display("FAIL clear_board: got %h want 0", board_seen); end
        if (lines_valid !== 1'b0)   begin errors++; $display("FAIL clear_pulse_end: got %b want 0", lines_valid); end
        if (piece_y !== 6'd23)      begin errors++; $display("FAIL clear_respawn_y: got %0d want 23", piece_y); end
    endtask

    task automatic test_cmd_gravity();
        cif.cmd_valid = 1'b1; cif.cmd = 3'd3; gravity_tick = 1'b1;
        tick();
        cif.cmd_valid = 1'b0; cif.cmd = 3'd0; gravity_tick = 1'b0;
        checks += 2;
        if (piece_x !== 5'sd2) begin errors++; $display("FAIL cmdgrav_x: got %0d want 2", piece_x); end
        if (piece_y !== 6'd23) begin errors++; $display("FAIL cmdgrav_y0: got %0d want 23", piece_y); end
        tick();
        checks++;
        if (piece_y !== 6'd22) begin errors++; $display("FAIL cmdgrav_pend: got %0d want 22", piece_y); end
        tick();
        checks++;
        if (piece_y !== 6'd22) begin errors++; $display("FAIL grav_once: got %0d want 22", piece_y); end
        gravity_tick = 1'b1;
        tick();
        gravity_tick = 1'b0;
        checks++;
        if (piece_y !== 6'd21) begin errors++; $display("FAIL grav_tick: got %0d want 21", piece_y); end
        do_cmd(3'd5);
        checks++;
        if (piece_y !== 6'd20) begin errors++; $display("FAIL soft_drop: got %0d want 20", piece_y); end
    endtask

    task automatic test_game_over();
        logic [N-1:0] exp;
        int           n;
        exp = '0;
        n = 0;
        for (int r = 0; r < H; r++) exp[r*W +: W] = 10'h078;
        for (int col = 3; col <= 6; col++)
            for (int k = 0; k < 5; k++)
                place_i((col == 3 && k == 0) ? 0 : col - 4, (col == 6 && k == 4) ? 3'd6 : 3'd0);
        checks += 2;
        if (piece_shape !== 16'h0660) begin errors++; $display("FAIL o_spawn: got %h want 0660", piece_shape); end
        if (game_over !== 1'b0)       begin errors++; $display("FAIL o_spawn_over: got %b want 0", game_over); end
        do_cmd(3'd6);
        while (!game_over && n < 60) begin
            tick();
            n++;
        end
        checks += 5;
        if (game_over !== 1'b1)     begin errors++; $display("FAIL top_out: game_over=%b want 1", game_over); end
        if (board !== exp)          begin errors++; $display("FAIL top_out_board: got %h want %h", board, exp); end
        if (piece_y !== 6'd22)      begin errors++; $display("FAIL top_out_y: got %0d want 22", piece_y); end
        if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL top_out_ready: got %b want 0", cif.cmd_ready); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL top_out_busy: got %b want 0", busy); end
        cif.cmd_valid = 1'b1; cif.cmd = 3'd3; gravity_tick = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        cif.cmd_valid = 1'b0; cif.cmd = 3'd0; gravity_tick = 1'b0;
        checks += 4;
        if (piece_x !== 5'sd3)  begin errors++; $display("FAIL over_cmd_x: got %0d want 3", piece_x); end
        if (piece_y !== 6'd22)  begin errors++; $display("FAIL over_cmd_y: got %0d want 22", piece_y); end
        if (game_over !== 1'b1) begin errors++; $display("FAIL over_stays: got %b want 1", game_over); end
        if (board !== exp)      begin errors++; $display("FAIL over_board: got %h want %h", board, exp); end
    endtask

    task automatic test_reset_mid_drop();
        rand_piece = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 2;
        if (board !== '0)  begin errors++; $display("FAIL restart_board: got %h want 0", board); end
        if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", busy); end
        wait_play("restart");
        place_i(1, 3'd0);
        do_cmd(3'd6);
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_drop_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #2;
        checks += 5;
        if (board !== '0)          begin errors++; $display("FAIL arst_board: got %h want 0", board); end
        if (game_over !== 1'b1)    begin errors++; $display("FAIL arst_over: got %b want 1", game_over); end
        if (piece_y !== 6'd23)     begin errors++; $display("FAIL arst_y: got %0d want 23", piece_y); end
        if (piece_shape !== 16'h0) begin errors++; $display("FAIL arst_shape: got %h want 0000", piece_shape); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef TETRIS_HOLD_EN
    task automatic test_hold();
        rand_piece = 3'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_play("hold_start");
        rand_piece = 3'd1;
        do_cmd(3'd7);
        checks++;
        if (hold_piece !== 4'd5) begin errors++; $display("FAIL hold_store: got %h want 5", hold_piece); end
        wait_play("hold_spawn");
        checks++;
        if (piece_shape !== 16'h0740) begin errors++; $display("FAIL hold_next: got %h want 0740", piece_shape); end
        do_cmd(3'd7);
        checks += 3;
        if (piece_shape !== 16'h0740) begin errors++; $display("FAIL hold_twice_shape: got %h want 0740", piece_shape); end
        if (hold_piece !== 4'd5)      begin errors++; $display("FAIL hold_twice: got %h want 5", hold_piece); end
        if (cif.cmd_ready !== 1'b1)   begin errors++; $display("FAIL hold_twice_ready: got %b want 1", cif.cmd_ready); end
        place_i(0, 3'd1);
        do_cmd(3'd7);
        checks += 4;
        if (piece_shape !== 16'h0E40) begin errors++; $display("FAIL hold_swap_shape: got %h want 0E40", piece_shape); end
        if (hold_piece !== 4'd1)      begin errors++; $display("FAIL hold_swap: got %h want 1", hold_piece); end
        if (piece_y !== 6'd23)        begin errors++; $display("FAIL hold_swap_y: got %0d want 23", piece_y); end
        if (cif.cmd_ready !== 1'b1)   begin errors++; $display("FAIL hold_swap_ready: got %b want 1", cif.cmd_ready); end
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        gravity_tick  = 1'b0;
        rand_piece    = 3'd0;
        cif.cmd_valid = 1'b0;
        cif.cmd       = 3'd0;
        test_reset();
        test_start();
        test_moves();
        test_line_clear();
        test_cmd_gravity();
        test_game_over();
        test_reset_mid_drop();
`ifdef TETRIS_HOLD_EN
        test_hold();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
